// File: rtl/se_sram_pkg.sv
// Shared helpers for SRAM front ends: lane sizing and round-robin grant search.
// Supports up to max_ports requesters.
package se_sram_pkg;

  localparam int max_ports = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } grant_t;

  function automatic int lane_width(input int data_width, input int we_width);
    return data_width / we_width;
  endfunction

  function automatic int rr_next(input int granted, input int n);
    return (granted + 1 >= n) ? 0 : granted + 1;
  endfunction

  // Scanning from the far end lets the requester closest to ptr be written last and win.
  function automatic grant_t first_set_from(input logic [max_ports-1:0] req,
                                            input int ptr, input int n);
    grant_t g;
    int     p;
    g = '0;
    for (int i = max_ports - 1; i >= 0; i--) begin
      if (i < n) begin
        p = ptr + i;
        if (p >= n) p = p - n;
        if (req[p[2:0]]) begin
          g.found = 1'b1;
          g.idx   = p[2:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/se_sram_srw_arbiter_if.sv
// Flattened per-port request bus between masters and the shared SRAM arbiter.
interface se_sram_srw_arbiter_if #(
  parameter int num_ports     = 2,
  parameter int address_width = 14,
  parameter int data_width    = 32,
  parameter int we_width      = 4
);
  logic [num_ports-1:0]               req;
  logic [num_ports-1:0]               read_not_write;
  logic [num_ports*address_width-1:0] address;
  logic [num_ports*data_width-1:0]    write_data;
  logic [num_ports*we_width-1:0]      write_enable;
  logic [num_ports-1:0]               ack;
  logic [num_ports-1:0]               rdata_valid;
  logic [data_width-1:0]              data_out;

  modport master (
    output req, read_not_write, address, write_data, write_enable,
    input  ack, rdata_valid, data_out
  );

  modport slave (
    input  req, read_not_write, address, write_data, write_enable,
    output ack, rdata_valid, data_out
  );
endinterface

// File: rtl/se_sram_srw_we.sv
// Single-port synchronous SRAM with per-lane write enables and registered read data.
module se_sram_srw_we
  import se_sram_pkg::*;
#(
  parameter         initfile      = "",
  parameter int     address_width = 14,
  parameter int     data_width    = 32,
  parameter int     we_width      = 4
) (
  input  logic                     clk,
  input  logic                     select,
  input  logic                     read_not_write,
  input  logic [address_width-1:0] address,
  input  logic [data_width-1:0]    write_data,
  input  logic [we_width-1:0]      write_enable,
  output logic [data_width-1:0]    data_out
);

  localparam int lane_w = lane_width(data_width, we_width);
  localparam int depth  = 1 << address_width;

  logic [data_width-1:0] mem [depth];

  // Preloading is left to the implementation flow's memory-init mechanism.
  if (initfile != "") begin : g_preload
  end

  always_ff @(posedge clk) begin
    if (select) begin
      if (read_not_write) begin
        data_out <= mem[address];
      end else begin
        for (int k = 0; k < we_width; k++) begin
          if (write_enable[k]) mem[address][k*lane_w +: lane_w] <= write_data[k*lane_w +: lane_w];
        end
      end
    end
  end

endmodule

// File: rtl/se_sram_srw_arbiter.sv
// N-port round-robin front end sharing one single-port SRAM, with held read data.
module se_sram_srw_arbiter
  import se_sram_pkg::*;
#(
  parameter         initfile      = "",
  parameter int     address_width = 14,
  parameter int     data_width    = 32,
  parameter int     we_width      = 4,
  parameter int     num_ports     = 2
) (
  input  logic                  sram_clock,
  input  logic                  reset_n,
  input  logic                  sram_clock__enable,
  se_sram_srw_arbiter_if.slave  bus
);

  localparam int rr_w = (num_ports > 1) ? $clog2(num_ports) : 1;

  logic [rr_w-1:0]          rr;
  logic [max_ports-1:0]     req_ext;
  grant_t                   grant;
  logic                     select;
  logic [num_ports-1:0]     ack;
  logic                     sel_rnw;
  logic [address_width-1:0] sel_addr;
  logic [data_width-1:0]    sel_wdata;
  logic [we_width-1:0]      sel_we;
  logic [num_ports-1:0]     rvalid_q;
  logic [data_width-1:0]    hold_q;
  logic [data_width-1:0]    sram_q;

  // Grant search and steering of the winning port's fields onto the SRAM.
  always_comb begin
    req_ext                  = '0;
    req_ext[num_ports-1:0]   = bus.req;
    grant                    = first_set_from(req_ext, int'(rr), num_ports);
    select                   = grant.found & sram_clock__enable;
    ack                      = '0;
    sel_rnw                  = 1'b1;
    sel_addr                 = '0;
    sel_wdata                = '0;
    sel_we                   = '0;
    for (int p = 0; p < num_ports; p++) begin
      if (grant.found && grant.idx == 3'(p)) begin
        ack[p]    = sram_clock__enable;
        sel_rnw   = bus.read_not_write[p];
        sel_addr  = bus.address[p*address_width +: address_width];
        sel_wdata = bus.write_data[p*data_width +: data_width];
        sel_we    = bus.write_enable[p*we_width +: we_width];
      end
    end
  end

  always_ff @(posedge sram_clock) begin
    if (!reset_n) begin
      rr       <= '0;
      rvalid_q <= '0;
      hold_q   <= '0;
    end else if (sram_clock__enable) begin
      if (select) rr <= rr_w'(rr_next(int'(grant.idx), num_ports));
      rvalid_q <= (select && sel_rnw) ? ack : '0;
      if (|rvalid_q) hold_q <= sram_q;
    end
  end

  se_sram_srw_we #(
    .initfile      (initfile),
    .address_width (address_width),
    .data_width    (data_width),
    .we_width      (we_width)
  ) u_sram (
    .clk            (sram_clock),
    .select         (select),
    .read_not_write (sel_rnw),
    .address        (sel_addr),
    .write_data     (sel_wdata),
    .write_enable   (sel_we),
    .data_out       (sram_q)
  );

  assign bus.ack         = ack;
  assign bus.rdata_valid = rvalid_q;
  assign bus.data_out    = (|rvalid_q) ? sram_q : hold_q;

endmodule

// File: tb/tb_se_sram_srw_arbiter.sv
// Directed bench for the three-port SRAM arbiter with hand-computed expectations.
module tb_se_sram_srw_arbiter;

  localparam int NP = 3;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int WW = 4;

  logic sram_clock = 1'b0;
  logic reset_n;
  logic sram_clock__enable;
  int   checks = 0;
  int   failures = 0;

  se_sram_srw_arbiter_if #(.num_ports(NP), .address_width(AW), .data_width(DW), .we_width(WW)) bus ();

  se_sram_srw_arbiter #(
    .initfile(""), .address_width(AW), .data_width(DW), .we_width(WW), .num_ports(NP)
  ) dut (
    .sram_clock         (sram_clock),
    .reset_n            (reset_n),
    .sram_clock__enable (sram_clock__enable),
    .bus                (bus)
  );

  always #5 sram_clock = ~sram_clock;

  task automatic step();
    @(posedge sram_clock);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req            = '0;
    bus.read_not_write = '1;
    bus.address        = '0;
    bus.write_data     = '0;
    bus.write_enable   = '0;
  endtask

  task automatic drive_port(input int p, input logic rnw, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [WW-1:0] we);
    bus.req[p]                   = 1'b1;
    bus.read_not_write[p]        = rnw;
    bus.address[p*AW +: AW]      = a;
    bus.write_data[p*DW +: DW]   = d;
    bus.write_enable[p*WW +: WW] = we;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (bus.ack !== 3'b000) begin
        failures++;
        $display("[TB] FAIL reset_ack cycle %0d: got %b expected 000", c, bus.ack);
      end
      checks++;
      if (bus.rdata_valid !== 3'b000) begin
        failures++;
        $display("[TB] FAIL reset_rvalid cycle %0d: got %b expected 000", c, bus.rdata_valid);
      end
      checks++;
      if (bus.data_out !== 32'h0000_0000) begin
        failures++;
        $display("[TB] FAIL reset_data cycle %0d: got %h expected 00000000", c, bus.data_out);
      end
    end
  endtask

  task automatic test_write_read();
    drive_port(0, 1'b0, 14'h0010, 32'hDEAD_BEEF, 4'b1111);
    checks++;
    if (bus.ack !== 3'b001) begin
      failures++;
      $display("[TB] FAIL wr_ack: got %b expected 001", bus.ack);
    end
    step();
    drive_port(0, 1'b1, 14'h0010, 32'h0, 4'b0000);
    checks++;
    if (bus.rdata_valid !== 3'b000) begin
      failures++;
      $display("[TB] FAIL wr_no_rvalid: got %b expected 000", bus.rdata_valid);
    end
    checks++;
    if (bus.ack !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rd_ack: got %b expected 001", bus.ack);
    end
    step();
    clear_reqs();
    checks++;
    if (bus.rdata_valid !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rd_rvalid: got %b expected 001", bus.rdata_valid);
    end
    checks++;
    if (bus.data_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL rd_data: got %h expected deadbeef", bus.data_out);
    end
    step();
    checks++;
    if (bus.rdata_valid !== 3'b000 || bus.data_out !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL rd_hold: got rvalid %b data %h expected 000 deadbeef", bus.rdata_valid, bus.data_out);
    end
  endtask

  task automatic test_lane_write();
    drive_port(0, 1'b0, 14'h0010, 32'h1122_3344, 4'b0101);
    step();
    drive_port(0, 1'b1, 14'h0010, 32'h0, 4'b0000);
    step();
    clear_reqs();
    checks++;
    if (bus.data_out !== 32'hDE22_BE44) begin
      failures++;
      $display("[TB] FAIL lane_data: got %h expected de22be44", bus.data_out);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] expected;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 14'(p), 32'h0, 4'b0000);
    for (int c = 0; c < 9; c++) begin
      expected = 3'b001 << (c % 3);
      checks++;
      if (bus.ack !== expected) begin
        failures++;
        $display("[TB] FAIL rr_ack cycle %0d: got %b expected %b", c, bus.ack, expected);
      end
      step();
    end
    clear_reqs();
    drive_port(2, 1'b1, 14'h0002, 32'h0, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.ack !== 3'b100) begin
        failures++;
        $display("[TB] FAIL rr_solo cycle %0d: got %b expected 100", c, bus.ack);
      end
      step();
    end
    clear_reqs();
    step();
  endtask

  task automatic test_enable_stall();
    drive_port(1, 1'b0, 14'h0020, 32'hCAFE_F00D, 4'b1111);
    step();
    drive_port(1, 1'b1, 14'h0020, 32'h0, 4'b0000);
    checks++;
    if (bus.ack !== 3'b010) begin
      failures++;
      $display("[TB] FAIL stall_rd_ack: got %b expected 010", bus.ack);
    end
    step();
    sram_clock__enable = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 3'b000) begin
      failures++;
      $display("[TB] FAIL stall_no_ack: got %b expected 000", bus.ack);
    end
    checks++;
    if (bus.rdata_valid !== 3'b010 || bus.data_out !== 32'hCAFE_F00D) begin
      failures++;
      $display("[TB] FAIL stall_rd_data: got rvalid %b data %h expected 010 cafef00d", bus.rdata_valid, bus.data_out);
    end
    step();
    checks++;
    if (bus.rdata_valid !== 3'b010) begin
      failures++;
      $display("[TB] FAIL stall_rvalid_held: got %b expected 010", bus.rdata_valid);
    end
    sram_clock__enable = 1'b1;
    clear_reqs();
    step();
    checks++;
    if (bus.rdata_valid !== 3'b000 || bus.data_out !== 32'hCAFE_F00D) begin
      failures++;
      $display("[TB] FAIL stall_hold: got rvalid %b data %h expected 000 cafef00d", bus.rdata_valid, bus.data_out);
    end
  endtask

  task automatic test_reset_read();
    drive_port(0, 1'b1, 14'h0010, 32'h0, 4'b0000);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rst_rd_ack: got %b expected 001", bus.ack);
    end
    step();
    reset_n = 1'b1;
    clear_reqs();
    #1;
    checks++;
    if (bus.rdata_valid !== 3'b000 || bus.data_out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rst_rd_cleared: got rvalid %b data %h expected 000 00000000", bus.rdata_valid, bus.data_out);
    end
    for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 14'(p), 32'h0, 4'b0000);
    checks++;
    if (bus.ack !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rst_rr_first: got %b expected 001", bus.ack);
    end
    step();
    checks++;
    if (bus.ack !== 3'b010) begin
      failures++;
      $display("[TB] FAIL rst_rr_second: got %b expected 010", bus.ack);
    end
    clear_reqs();
    step();
  endtask

  initial begin
    reset_n            = 1'b0;
    sram_clock__enable = 1'b1;
    clear_reqs();
    test_reset();
    test_write_read();
    test_lane_write();
    test_round_robin();
    test_enable_stall();
    test_reset_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
